// File: rtl/zero_count_sequencer_pkg.sv
// ============================================================================
// Module      : zero_count_sequencer_pkg
// Description : Shared constants for the zero-count sequencer and its
//               companion serial 8-bit zero counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package zero_count_sequencer_pkg;

  // Zero counter interface widths
  localparam int CC_DATA_W  = 8;
  localparam int CC_COUNT_W = 4;

  // Nominal zero-counter latency, in cycles after the start cycle
  localparam int CC_LATENCY = 10;

  // Sequencer state encoding
  localparam int          c_state_w   = 2;
  localparam logic [1:0]  c_st_idle   = 2'd0;
  localparam logic [1:0]  c_st_issue  = 2'd1;
  localparam logic [1:0]  c_st_wait   = 2'd2;
  localparam logic [1:0]  c_st_out    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/zero_count_sequencer.sv
// ============================================================================
// Module      : zero_count_sequencer
// Description : Feeds a framed byte stream into the serial zero counter one
//               byte at a time, accumulates the per-byte zero counts, and
//               presents the frame total and byte count on a valid/ready
//               output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zero_count_sequencer
  import zero_count_sequencer_pkg::*;
#(
  parameter  int MAX_BYTES = 16,
  parameter  int TOTAL_W   = 8,
  parameter  int TIMEOUT   = 32,
  localparam int NB_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CC_DATA_W-1:0]  in_byte,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [CC_DATA_W-1:0]  cc_a,
  output logic                  cc_start,
  input  logic [CC_COUNT_W-1:0] cc_count,
  input  logic                  cc_done,
  output logic [TOTAL_W-1:0]    total,
  output logic [NB_W-1:0]       nbytes,
  output logic                  ovf,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int              TMO_W      = $clog2(TIMEOUT + 1);
  localparam int              SUM_W      = TOTAL_W + 1;
  localparam logic [NB_W-1:0] c_max_nb   = NB_W'(MAX_BYTES);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT - 1);

  logic [c_state_w-1:0]  r_state;
  logic [CC_DATA_W-1:0]  r_cc_a;
  logic                  r_last;
  logic [TMO_W-1:0]      r_tmo;
  logic [TOTAL_W-1:0]    r_total;
  logic [NB_W-1:0]       r_nbytes;
  logic                  r_ovf;
  logic                  r_err;

  logic [SUM_W-1:0]      w_sum;
  logic [TOTAL_W-1:0]    w_total_sat;
  logic [c_state_w-1:0]  w_after_byte;

  // Saturating accumulate of the counter result; carry-out means overflow
  always_comb begin
    w_sum       = {1'b0, r_total} + SUM_W'(cc_count);
    w_total_sat = w_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : w_sum[TOTAL_W-1:0];
    w_after_byte = r_last ? c_st_out : c_st_idle;
  end

  // Handshake and strobe outputs decode directly from the state register
  assign in_ready  = (r_state == c_st_idle);
  assign cc_start  = (r_state == c_st_issue);
  assign out_valid = (r_state == c_st_out);
  assign cc_a      = r_cc_a;
  assign total     = r_total;
  assign nbytes    = r_nbytes;
  assign ovf       = r_ovf;
  assign err       = r_err;

  // Frame sequencing: accept, issue, wait for the counter, report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_st_idle;
      r_cc_a   <= '0;
      r_last   <= 1'b0;
      r_tmo    <= '0;
      r_total  <= '0;
      r_nbytes <= '0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_cc_a <= in_byte;
            r_last <= in_last;
            if (r_nbytes < c_max_nb) begin
              r_state <= c_st_issue;
            end else begin
              // Frame already full: byte is dropped, only the flag records it
              r_ovf <= 1'b1;
              if (in_last) begin
                r_state <= c_st_out;
              end
            end
          end
        end
        c_st_issue: begin
          // Counter's stale done is ignored here; it clears at this edge
          r_tmo   <= '0;
          r_state <= c_st_wait;
        end
        c_st_wait: begin
          if (cc_done) begin
            r_total  <= w_total_sat;
            r_nbytes <= r_nbytes + NB_W'(1);
            r_state  <= w_after_byte;
          end else if (r_tmo == c_tmo_last) begin
            r_err   <= 1'b1;
            r_state <= w_after_byte;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        c_st_out: begin
          if (out_ready) begin
            r_total  <= '0;
            r_nbytes <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_state  <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_zero_count_sequencer.sv
// ============================================================================
// Module      : tb_zero_count_sequencer
// Description : Self-checking bench for zero_count_sequencer with a
//               behavioural zero-counter stub and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zero_count_sequencer;
  import zero_count_sequencer_pkg::*;

  localparam int MAX_BYTES = 16;
  localparam int TOTAL_W   = 8;
  localparam int TIMEOUT   = 32;
  localparam int NB_W      = $clog2(MAX_BYTES + 1);

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [TOTAL_W-1:0] total;
    logic [NB_W-1:0]    nbytes;
    logic               ovf;
    logic               err;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [7:0]            in_byte;
  logic                  in_last;
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            cc_a;
  logic                  cc_start;
  logic [3:0]            cc_count = 4'd0;
  logic                  cc_done  = 1'b0;
  logic [TOTAL_W-1:0]    total;
  logic [NB_W-1:0]       nbytes;
  logic                  ovf;
  logic                  err;
  logic                  out_valid;
  logic                  out_ready;

  int   checks     = 0;
  int   errors     = 0;
  int   start_cnt  = 0;
  int   a_unstable = 0;
  exp_t sb[$];

  // Zero-counter stub state
  logic       stub_dead = 1'b0;
  logic       stub_busy = 1'b0;
  logic [7:0] stub_a    = 8'd0;
  int         stub_cnt  = 0;

  zero_count_sequencer #(
    .MAX_BYTES (MAX_BYTES),
    .TOTAL_W   (TOTAL_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cc_a      (cc_a),
    .cc_start  (cc_start),
    .cc_count  (cc_count),
    .cc_done   (cc_done),
    .total     (total),
    .nbytes    (nbytes),
    .ovf       (ovf),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic int zeros_of(input logic [7:0] b);
    int z;
    z = 0;
    for (int i = 0; i < 8; i++) if (b[i] == 1'b0) z++;
    return z;
  endfunction

  // Behavioural zero counter: no reset, done held until the next start
  always @(posedge clk) begin
    if (cc_start === 1'b1) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 0;
      cc_done   <= 1'b0;
      stub_a    <= cc_a;
    end else if (stub_busy) begin
      if (in_ready === 1'b0 && out_valid === 1'b0 && cc_a !== stub_a)
        a_unstable <= a_unstable + 1;
      if (stub_cnt == CC_LATENCY - 1 && !stub_dead) begin
        cc_done   <= 1'b1;
        cc_count  <= 4'(zeros_of(stub_a));
        stub_busy <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  // Start-pulse monitor
  always @(posedge clk) begin
    if (cc_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  // Present one byte; entered and left on a negative edge
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL in_ready_wait got %b want 1", in_ready);
    end else begin
      in_byte  = b;
      in_last  = last;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
    end
  endtask

  // Push the frame's expected result, then drive its bytes
  task automatic send_frame(input byte_q_t bytes, input logic dead);
    exp_t e;
    int   t;
    e.total = '0; e.nbytes = '0; e.ovf = 1'b0; e.err = 1'b0;
    t = 0;
    foreach (bytes[i]) begin
      if (int'(e.nbytes) < MAX_BYTES) begin
        if (dead) e.err = 1'b1;
        else begin
          t = t + zeros_of(bytes[i]);
          if (t > 2**TOTAL_W - 1) t = 2**TOTAL_W - 1;
          e.nbytes = e.nbytes + 1'b1;
        end
      end else begin
        e.ovf = 1'b1;
      end
    end
    e.total = TOTAL_W'(t);
    sb.push_back(e);
    foreach (bytes[i]) send_byte(bytes[i], (i == bytes.size() - 1));
  endtask

  // Wait for a result, compare against the scoreboard, hold, then release
  task automatic collect(input int hold);
    int   n;
    exp_t e;
    logic stable;
    n = 0;
    while (out_valid !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL result_wait out_valid %b queued %0d want 1 and >0", out_valid, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      checks++;
      if (total !== e.total) begin errors++; $display("FAIL total got %0d want %0d", total, e.total); end
      checks++;
      if (nbytes !== e.nbytes) begin errors++; $display("FAIL nbytes got %0d want %0d", nbytes, e.nbytes); end
      checks++;
      if (ovf !== e.ovf) begin errors++; $display("FAIL ovf got %b want %b", ovf, e.ovf); end
      checks++;
      if (err !== e.err) begin errors++; $display("FAIL err got %b want %b", err, e.err); end
      if (hold > 0) begin
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          if (out_valid !== 1'b1 || in_ready !== 1'b0 || total !== e.total ||
              nbytes !== e.nbytes || ovf !== e.ovf || err !== e.err)
            stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin errors++; $display("FAIL hold_stable got %b want 1", stable); end
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || total !== '0 || nbytes !== '0 ||
        ovf !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL cleared got rdy %b vld %b total %0d nb %0d ovf %b err %b want 1 0 0 0 0 0",
               in_ready, out_valid, total, nbytes, ovf, err);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || cc_start !== 1'b0 || cc_a !== 8'h00 ||
        total !== '0 || nbytes !== '0 || ovf !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s got rdy %b vld %b start %b a %h total %0d nb %0d ovf %b err %b want 1 0 0 00 0 0 0 0",
               tag, in_ready, out_valid, cc_start, cc_a, total, nbytes, ovf, err);
    end
  endtask

  task automatic check_starts(input int s0, input int want);
    checks++;
    if (start_cnt - s0 !== want) begin
      errors++;
      $display("FAIL start_pulses got %0d want %0d", start_cnt - s0, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_byte = 8'h00; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_asserted");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset_released");
  endtask

  task automatic test_single_byte();
    byte_q_t q;
    int s0;
    s0 = start_cnt;
    q = '{8'h00};
    send_frame(q, 1'b0);
    collect(0);
    check_starts(s0, 1);
  endtask

  task automatic test_multi_byte();
    byte_q_t q;
    int s0, u0;
    s0 = start_cnt;
    u0 = a_unstable;
    q = '{8'hFF, 8'h0F, 8'hA5};
    send_frame(q, 1'b0);
    collect(0);
    check_starts(s0, 3);
    checks++;
    if (a_unstable - u0 != 0) begin
      errors++;
      $display("FAIL cc_a_stable got %0d changes want 0", a_unstable - u0);
    end
  endtask

  task automatic test_backpressure();
    byte_q_t q;
    q = '{8'h01, 8'h80};
    send_frame(q, 1'b0);
    collect(20);
  endtask

  task automatic test_overflow();
    byte_q_t q;
    int s0;
    s0 = start_cnt;
    for (int i = 0; i < MAX_BYTES + 2; i++) q.push_back(8'h00);
    send_frame(q, 1'b0);
    collect(0);
    check_starts(s0, MAX_BYTES);
  endtask

  task automatic test_timeout();
    byte_q_t q;
    int n;
    stub_dead = 1'b1;
    q = '{8'h55};
    send_frame(q, 1'b1);
    // Now in the ISSUE cycle; OUT follows TIMEOUT wait cycles later
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_latency got %0d want %0d", n, TIMEOUT + 1);
    end
    collect(0);
    stub_dead = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    byte_q_t q;
    int s0;
    s0 = start_cnt;
    send_byte(8'h3C, 1'b0);
    send_byte(8'h81, 1'b0);
    repeat (3) @(negedge clk);
    check_starts(s0, 2);
    checks++;
    if (nbytes !== 5'd1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait got nb %0d rdy %b want 1 0", nbytes, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("after_async_reset");
    q = '{8'hF0};
    send_frame(q, 1'b0);
    collect(0);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_backpressure();
    test_overflow();
    test_timeout();
    test_reset_mid_frame();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
